mem_stage_access_unit: RTL

- Memory-access stage between the EX/MEM and MEM/WB pipeline barriers.
- Performs data-memory loads and stores over a req/ack bus, with byte/halfword lane steering and load sign/zero extension.
- Stalls the pipeline while a bus access is outstanding, and presents the result to MEM/WB as memMemoryData, memExecutionData, memWriteRegisterIndex, memMemToReg and memRegWrite.

---
 rtl/mem_stage_access_unit.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_access_unit.sv
// Memory-access pipeline stage: drives a req/ack data bus for loads and stores,
// steers byte lanes, extends load data and stalls the pipeline while the bus is busy.
module mem_stage_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [31:0] memAluResult,
  input  logic [31:0] memWriteData,
  input  logic        memMemRead,
  input  logic        memMemWrite,
  input  logic [2:0]  memFunct3,
  input  logic [4:0]  memWriteRegisterIndexIn,
  input  logic        memMemToRegIn,
  input  logic        memRegWriteIn,
  input  logic        busAck,
  input  logic [31:0] busRdata,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWdata,
  output logic [3:0]  busWstrb,
  output logic [31:0] memMemoryData,
  output logic [31:0] memExecutionData,
  output logic [4:0]  memWriteRegisterIndex,
  output logic        memMemToReg,
  output logic        memRegWrite,
  output logic        memStall,
  output logic        memAccessFault
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  // The counter already holds the IDLE request cycle, so the limit is one less.
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state_r;
  logic [31:0]   loadData_r;
  logic          fault_r;
  logic [CW-1:0] count_r;

  logic [1:0] offset_s;
  logic       isAccess_s;
  logic       isLoad_s;
  logic       isStore_s;
  logic       badAccess_s;
  logic       fault_s;
  logic       timeout_s;
  logic       reqRaw_s;
  logic       stallRaw_s;
  logic       faultRaw_s;

  function automatic logic [31:0] extractLoad(input logic [31:0] rdata,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  offset);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{offset, 3'b000} +: 8];
    h = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = rdata;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] storeLanes(input logic [31:0] wd, input logic [1:0] size);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] storeStrobe(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] r;
    case (size)
      2'b00:   r = 4'b0001 << offset;
      2'b01:   r = 4'b0011 << offset;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Decode access kind, alignment/illegal-size faults and the timeout condition.
  always_comb begin
    offset_s    = memAluResult[1:0];
    isAccess_s  = memMemRead | memMemWrite;
    isStore_s   = memMemWrite;
    isLoad_s    = memMemRead & ~memMemWrite;
    badAccess_s = 1'b0;
    case (memFunct3)
      3'b000, 3'b100: badAccess_s = 1'b0;
      3'b001, 3'b101: badAccess_s = offset_s[0];
      3'b010:         badAccess_s = (offset_s != 2'b00);
      default:        badAccess_s = 1'b1;
    endcase
    fault_s = isAccess_s & badAccess_s;
    if ((TIMEOUT_CYCLES != 0) && (state_r == ST_WAIT)) begin
      timeout_s = (count_r >= TO_LIMIT);
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Access sequencer: IDLE -> WAIT -> DONE, capturing load data or a timeout fault.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r    <= ST_IDLE;
      loadData_r <= 32'h0000_0000;
      fault_r    <= 1'b0;
      count_r    <= CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          fault_r <= 1'b0;
          if (isAccess_s && !fault_s) begin
            state_r <= ST_WAIT;
            count_r <= CNT_ONE;
          end
        end
        ST_WAIT: begin
          if (busAck) begin
            loadData_r <= isLoad_s ? extractLoad(busRdata, memFunct3, offset_s) : 32'h0000_0000;
            state_r    <= ST_DONE;
            count_r    <= CNT_ZERO;
          end else if (timeout_s) begin
            loadData_r <= 32'h0000_0000;
            fault_r    <= 1'b1;
            state_r    <= ST_DONE;
            count_r    <= CNT_ZERO;
          end else if (count_r != CNT_MAX) begin
            count_r <= count_r + CNT_ONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          fault_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          fault_r <= 1'b0;
          count_r <= CNT_ZERO;
        end
      endcase
    end
  end

  // Bus and MEM/WB outputs; request, stall and fault are forced low while in reset.
  always_comb begin
    busAddr               = {memAluResult[31:2], 2'b00};
    memExecutionData      = memAluResult;
    memWriteRegisterIndex = memWriteRegisterIndexIn;
    memMemToReg           = memMemToRegIn;
    memMemoryData         = 32'h0000_0000;
    memRegWrite           = memRegWriteIn;
    reqRaw_s              = 1'b0;
    stallRaw_s            = 1'b0;
    faultRaw_s            = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fault_s) begin
          memRegWrite = 1'b0;
          faultRaw_s  = 1'b1;
        end else if (isAccess_s) begin
          memRegWrite = 1'b0;
          reqRaw_s    = 1'b1;
          stallRaw_s  = 1'b1;
        end else begin
          memRegWrite = memRegWriteIn;
        end
      end
      ST_WAIT: begin
        memRegWrite = 1'b0;
        reqRaw_s    = 1'b1;
        stallRaw_s  = 1'b1;
      end
      ST_DONE: begin
        memMemoryData = loadData_r;
        memRegWrite   = memRegWriteIn & ~fault_r;
        faultRaw_s    = fault_r;
      end
      default: begin
        memRegWrite = 1'b0;
      end
    endcase

    if (resetN && reqRaw_s) begin
      busReq = 1'b1;
      busWe  = isStore_s;
    end else begin
      busReq = 1'b0;
      busWe  = 1'b0;
    end
    if (busWe) begin
      busWdata = storeLanes(memWriteData, memFunct3[1:0]);
      busWstrb = storeStrobe(memFunct3[1:0], offset_s);
    end else begin
      busWdata = 32'h0000_0000;
      busWstrb = 4'b0000;
    end
    memStall       = resetN & stallRaw_s;
    memAccessFault = resetN & faultRaw_s;
  end

endmodule
